// File: rtl/pkt_queue_dispatcher.sv
// pkt_queue_dispatcher: steers whole AXI-Stream packets to C_NUM_QUEUES caches and tags the matching PHV with the queue index (one-hot).
// Define DISPATCH_SKIP_BUSY_EN to let a new packet skip queues whose ready is low.
module pkt_queue_dispatcher #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES         = 4,
  parameter int PKT_HDR_LEN          = 1024,
  parameter int C_QTAG_LSB           = 141,
  parameter int C_TAG_FIFO_DEPTH     = 8
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic [C_NUM_QUEUES-1:0]           m_axis_tvalid,
  input  logic [C_NUM_QUEUES-1:0]           m_axis_tready,
  input  logic [PKT_HDR_LEN-1:0]            s_phv,
  input  logic                              s_phv_valid,
  output logic [PKT_HDR_LEN-1:0]            pkt_hdr_vec,
  output logic                              parser_valid,
  output logic                              tag_underflow,
  output logic                              tag_fifo_full
);
  localparam int QW = $clog2(C_NUM_QUEUES);
  localparam int AW = $clog2(C_TAG_FIFO_DEPTH);
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state, state_nxt;
  logic [QW-1:0] rr_ptr, lock_q, sel, rr_sel;
  logic [QW-1:0] mem [C_TAG_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nxt;
  logic beat, sop, pop, empty;
  logic [C_NUM_QUEUES-1:0] tag_onehot;
`ifdef DISPATCH_SKIP_BUSY_EN
  logic [QW:0] s;
  // scan farthest-first so the queue nearest rr_ptr wins
  always_comb begin
    rr_sel = rr_ptr;
    s = '0;
    for (int k = C_NUM_QUEUES - 1; k >= 0; k--) begin
      s = {1'b0, rr_ptr} + (QW+1)'(k);
      if (s >= (QW+1)'(C_NUM_QUEUES)) s = s - (QW+1)'(C_NUM_QUEUES);
      if (m_axis_tready[s[QW-1:0]]) rr_sel = s[QW-1:0];
    end
  end
`else
  always_comb rr_sel = rr_ptr;
`endif
  assign sel = state == IN_PKT ? lock_q : rr_sel;
  assign s_axis_tready = m_axis_tready[sel] & (state == IN_PKT | ~tag_fifo_full);
  assign beat = s_axis_tvalid & s_axis_tready;
  assign sop = beat & (state == IDLE);
  assign empty = count == '0;
  assign pop = s_phv_valid & ~empty;
  assign count_nxt = count + (AW+1)'(sop) - (AW+1)'(pop);
  assign tag_onehot = empty ? '0 : C_NUM_QUEUES'(1) << mem[rd_ptr];
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tuser = s_axis_tuser;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tlast = s_axis_tlast;
  always_comb begin
    m_axis_tvalid = '0;
    for (int q = 0; q < C_NUM_QUEUES; q++) m_axis_tvalid[q] = s_axis_tvalid && sel == QW'(q);
  end
  always_comb state_nxt = !beat ? state : s_axis_tlast ? IDLE : IN_PKT;
  always_ff @(posedge axis_clk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge axis_clk or negedge aresetn)
    if (!aresetn) begin
      rr_ptr <= '0;
      lock_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      tag_fifo_full <= 1'b0;
      tag_underflow <= 1'b0;
      parser_valid <= 1'b0;
      pkt_hdr_vec <= '0;
    end else begin
      if (sop) begin
        lock_q <= sel;
        rr_ptr <= sel == QW'(C_NUM_QUEUES - 1) ? '0 : sel + QW'(1);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      tag_fifo_full <= count_nxt == (AW+1)'(C_TAG_FIFO_DEPTH);
      tag_underflow <= tag_underflow | (s_phv_valid & empty);
      parser_valid <= s_phv_valid;
      if (s_phv_valid) begin
        pkt_hdr_vec <= s_phv;
        pkt_hdr_vec[C_QTAG_LSB +: C_NUM_QUEUES] <= tag_onehot;
      end
    end
  always_ff @(posedge axis_clk)
    if (sop) mem[wr_ptr] <= sel;
endmodule
